// File: rtl/elev_pkg.sv
// Shared constants and state encoding for the elevator car controller.
// Also used by the logic around the floor-indicator decoder.
package elev_pkg;
  localparam int FLOOR_W   = 4;
  localparam int N_FLOORS  = 8;
  localparam int FLOOR_MIN = 1;
  localparam int FLOOR_MAX = 8;
  localparam int TMR_W     = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } elev_state_t;

  // One-hot pending/request bit for a floor code (bit i = floor i+1).
  function automatic logic [N_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    logic [N_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (int'(f) == i + FLOOR_MIN) m[i] = 1'b1;
    end
    return m;
  endfunction
endpackage

// File: rtl/elev_req_scan.sv
// Combinational request scan: are there requests above, below or at a floor.
module elev_req_scan
  import elev_pkg::*;
(
  input  logic [N_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]  floor,
  output logic                above,
  output logic                below,
  output logic                here
);
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    here  = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending[i]) begin
        if (i + FLOOR_MIN > int'(floor))      above = 1'b1;
        else if (i + FLOOR_MIN < int'(floor)) below = 1'b1;
        else                                  here  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/elev_car_ctrl.sv
// SCAN elevator car controller: request latch, floor-by-floor travel, door timing.
// Optional door-hold input is enabled by defining ELEV_DOOR_HOLD_EN.
module elev_car_ctrl
  import elev_pkg::*;
#(
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [N_FLOORS-1:0] req_btn,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic                door_hold,
`endif
  output logic [FLOOR_W-1:0]  floor,
  output logic                moving_up,
  output logic                moving_down,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending
);
  localparam logic [TMR_W-1:0] TRAVEL_LAST = TMR_W'(TRAVEL_TICKS - 1);
  localparam logic [TMR_W-1:0] DOOR_LAST   = TMR_W'(DOOR_TICKS - 1);

  elev_state_t         r_state;
  logic [FLOOR_W-1:0]  r_floor;
  logic [N_FLOORS-1:0] r_pending;
  logic                r_last_up;
  logic [TMR_W-1:0]    r_timer;

  logic [N_FLOORS-1:0] w_pend_in;
  logic [N_FLOORS-1:0] w_clr;
  logic [FLOOR_W-1:0]  w_floor_nxt;
  logic                w_cur_above, w_cur_below, w_cur_here;
  logic                w_nxt_above, w_nxt_below, w_nxt_here;
  logic                w_req_here, w_hold, w_arrive;

  assign w_pend_in   = r_pending | req_btn;
  assign w_floor_nxt = (r_state == MOVE_DOWN) ? r_floor - FLOOR_W'(1) : r_floor + FLOOR_W'(1);
  assign w_req_here  = |(req_btn & floor_bit(r_floor));
  assign w_arrive    = ((r_state == MOVE_UP) || (r_state == MOVE_DOWN)) && tick &&
                       (r_timer == TRAVEL_LAST);

`ifdef ELEV_DOOR_HOLD_EN
  assign w_hold = door_hold;
`else
  assign w_hold = 1'b0;
`endif

  elev_req_scan u_scan_cur (
    .pending (r_pending),
    .floor   (r_floor),
    .above   (w_cur_above),
    .below   (w_cur_below),
    .here    (w_cur_here)
  );

  // Arrival decisions look at the floor being reached, including same-cycle calls.
  elev_req_scan u_scan_nxt (
    .pending (w_pend_in),
    .floor   (w_floor_nxt),
    .above   (w_nxt_above),
    .below   (w_nxt_below),
    .here    (w_nxt_here)
  );

  always_comb begin
    w_clr = '0;
    case (r_state)
      IDLE:              if (w_cur_here) w_clr = floor_bit(r_floor);
      MOVE_UP, MOVE_DOWN: if (w_arrive && w_nxt_here) w_clr = floor_bit(w_floor_nxt);
      DOOR:              w_clr = floor_bit(r_floor);
      default:           w_clr = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_floor   <= FLOOR_W'(FLOOR_MIN);
      r_pending <= '0;
      r_last_up <= 1'b1;
      r_timer   <= '0;
    end else begin
      r_pending <= w_pend_in & ~w_clr;
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (w_cur_here)                       r_state <= DOOR;
          else if (w_cur_above && w_cur_below)  r_state <= r_last_up ? MOVE_UP : MOVE_DOWN;
          else if (w_cur_above)                 r_state <= MOVE_UP;
          else if (w_cur_below)                 r_state <= MOVE_DOWN;
        end
        MOVE_UP, MOVE_DOWN: begin
          if (w_arrive) begin
            r_floor   <= w_floor_nxt;
            r_timer   <= '0;
            r_last_up <= (r_state == MOVE_UP);
            if (w_nxt_here) r_state <= DOOR;
            else if ((r_state == MOVE_UP) ? !w_nxt_above : !w_nxt_below) r_state <= IDLE;
          end else if (tick) begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        DOOR: begin
          // A call for this floor while open reopens the door instead of latching.
          if (w_req_here || w_hold) begin
            r_timer <= '0;
          end else if (tick) begin
            if (r_timer == DOOR_LAST) begin
              r_state <= IDLE;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + TMR_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign floor       = r_floor;
  assign pending     = r_pending;
  assign moving_up   = (r_state == MOVE_UP);
  assign moving_down = (r_state == MOVE_DOWN);
  assign door_open   = (r_state == DOOR);
endmodule

// File: tb/tb_elev_car_ctrl.sv
// Bench for elev_car_ctrl: floor-indexed behavioural model compared every cycle,
// plus literal checkpoints. Hold scenario is included when ELEV_DOOR_HOLD_EN is defined.
module tb_elev_car_ctrl;
  localparam int TT = 4;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] req_btn = 8'h00;
`ifdef ELEV_DOOR_HOLD_EN
  logic       door_hold = 1'b0;
`endif
  logic [3:0] floor;
  logic       moving_up, moving_down, door_open;
  logic [7:0] pending;

  int n_pass = 0;
  int n_chk  = 0;

  elev_car_ctrl #(.TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .req_btn     (req_btn),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold   (door_hold),
`endif
    .floor       (floor),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .door_open   (door_open),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  // Model: car position as an integer floor, calls as a floor-indexed bit set,
  // and a count of strobes spent in the current travel leg or door opening.
  typedef enum int {M_IDLE, M_UP, M_DOWN, M_DOOR} mmode_t;
  int       m_floor   = 1;
  mmode_t   m_mode    = M_IDLE;
  bit [8:1] m_pend    = '0;
  bit       m_last_up = 1'b1;
  int       m_ticks   = 0;

  function automatic bit calls_beyond(bit [8:1] p, int f, bit up);
    for (int k = 1; k <= 8; k++) begin
      if (p[k] && (up ? (k > f) : (k < f))) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    bit [8:1] req;
    bit [8:1] nxt;
    bit       hold;
    bit       up;
    req  = req_btn;
    nxt  = m_pend | req;
    hold = 1'b0;
`ifdef ELEV_DOOR_HOLD_EN
    hold = door_hold;
`endif
    case (m_mode)
      M_IDLE: begin
        m_ticks = 0;
        if (m_pend[m_floor]) begin
          m_mode = M_DOOR;
          nxt[m_floor] = 1'b0;
        end else if (calls_beyond(m_pend, m_floor, 1'b1) && calls_beyond(m_pend, m_floor, 1'b0))
          m_mode = m_last_up ? M_UP : M_DOWN;
        else if (calls_beyond(m_pend, m_floor, 1'b1)) m_mode = M_UP;
        else if (calls_beyond(m_pend, m_floor, 1'b0)) m_mode = M_DOWN;
      end
      M_UP, M_DOWN: begin
        if (tick) begin
          m_ticks++;
          if (m_ticks == TT) begin
            up        = (m_mode == M_UP);
            m_floor   = up ? m_floor + 1 : m_floor - 1;
            m_ticks   = 0;
            m_last_up = up;
            if (nxt[m_floor]) begin
              m_mode = M_DOOR;
              nxt[m_floor] = 1'b0;
            end else if (!calls_beyond(nxt, m_floor, up)) begin
              m_mode = M_IDLE;
            end
          end
        end
      end
      M_DOOR: begin
        nxt[m_floor] = 1'b0;
        if (req[m_floor] || hold) m_ticks = 0;
        else if (tick) begin
          m_ticks++;
          if (m_ticks == DT) begin
            m_mode  = M_IDLE;
            m_ticks = 0;
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
    m_pend = nxt;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_floor = 1; m_mode = M_IDLE; m_pend = '0; m_last_up = 1'b1; m_ticks = 0;
    end else begin
      model_step();
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    check("floor",       int'(floor),       m_floor);
    check("moving_up",   int'(moving_up),   int'(m_mode == M_UP));
    check("moving_down", int'(moving_down), int'(m_mode == M_DOWN));
    check("door_open",   int'(door_open),   int'(m_mode == M_DOOR));
    check("pending",     int'(pending),     int'(m_pend));
  end

  task automatic step(input bit tk, input logic [7:0] rb);
    tick = tk;
    req_btn = rb;
    @(posedge clk);
    #1;
    tick = 1'b0;
    req_btn = 8'h00;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 8'h00);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_floor",   int'(floor),   1);
    check("rst_pending", int'(pending), 0);
    check("rst_flags",   int'({moving_up, moving_down, door_open}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_floor",   int'(floor),   1);
    check("reset_pending", int'(pending), 0);
    check("reset_flags",   int'({moving_up, moving_down, door_open}), 0);

    // Call at the current floor
    step(1'b0, 8'h01);
    check("t1_latched", int'(pending), 8'h01);
    check("t1_closed",  int'(door_open), 0);
    step(1'b0, 8'h00);
    check("t1_open",    int'(door_open), 1);
    check("t1_cleared", int'(pending), 0);
    ticks(2);
    check("t1_still_open", int'(door_open), 1);
    ticks(1);
    check("t1_closed_after", int'(door_open), 0);
    check("t1_floor", int'(floor), 1);

    // Full run to the top floor
    step(1'b0, 8'h80);
    step(1'b0, 8'h00);
    check("t2_up", int'(moving_up), 1);
    ticks(27);
    check("t2_floor7", int'(floor), 7);
    check("t2_still_up", int'(moving_up), 1);
    ticks(1);
    check("t2_floor8", int'(floor), 8);
    check("t2_door", int'(door_open), 1);
    check("t2_pending", int'(pending), 0);
    ticks(3);
    ticks(2);
    check("t2_idle_tick_floor", int'(floor), 8);

    async_reset();

    // SCAN: stop at 6 on the way up, then reverse to 2
    step(1'b0, 8'h20);
    step(1'b0, 8'h00);
    ticks(12);
    check("t3_floor4", int'(floor), 4);
    step(1'b0, 8'h22);
    check("t3_pending", int'(pending), 8'h22);
    ticks(8);
    check("t3_floor6", int'(floor), 6);
    check("t3_door6", int'(door_open), 1);
    check("t3_left", int'(pending), 8'h02);
    ticks(3);
    check("t3_idle", int'({moving_up, moving_down, door_open}), 0);
    step(1'b0, 8'h00);
    check("t3_down", int'(moving_down), 1);
    ticks(16);
    check("t3_floor2", int'(floor), 2);
    check("t3_door2", int'(door_open), 1);
    check("t3_empty", int'(pending), 0);
    ticks(3);

    // Call for the arrival floor on the arrival strobe
    step(1'b0, 8'h08);
    step(1'b0, 8'h00);
    ticks(3);
    step(1'b1, 8'h04);
    check("t4_floor3", int'(floor), 3);
    check("t4_door3", int'(door_open), 1);
    check("t4_pending", int'(pending), 8'h08);
    ticks(3);
    step(1'b0, 8'h00);
    check("t4_up", int'(moving_up), 1);
    ticks(4);
    check("t4_floor4", int'(floor), 4);
    check("t4_door4", int'(door_open), 1);
    ticks(3);

    // Door reopen at floor 5
    step(1'b0, 8'h10);
    step(1'b0, 8'h00);
    ticks(4);
    check("t5_floor5", int'(floor), 5);
    ticks(1);
    step(1'b0, 8'h10);
    check("t5_not_latched", int'(pending), 0);
    check("t5_open", int'(door_open), 1);
    ticks(2);
    check("t5_still_open", int'(door_open), 1);
    ticks(1);
    check("t5_closed", int'(door_open), 0);

    // Calls both ways with last direction up
    step(1'b0, 8'h81);
    step(1'b0, 8'h00);
    check("t6_prefers_up", int'(moving_up), 1);
    ticks(2);

    async_reset();

    // Reset mid-travel at floor 3
    step(1'b0, 8'h40);
    step(1'b0, 8'h00);
    ticks(9);
    check("t7_floor3", int'(floor), 3);
    check("t7_pending", int'(pending), 8'h40);
    async_reset();

`ifdef ELEV_DOOR_HOLD_EN
    step(1'b0, 8'h01);
    step(1'b0, 8'h00);
    door_hold = 1'b1;
    ticks(10);
    check("t8_held", int'(door_open), 1);
    door_hold = 1'b0;
    ticks(2);
    check("t8_open_after_release", int'(door_open), 1);
    ticks(1);
    check("t8_closed", int'(door_open), 0);
`endif

    ticks(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
